hilo_muldiv_ctrl: RTL

//  Multi-cycle multiply/divide sequencer that produces the HI/LO result pair and its write strobe for the HI/LO register.

---
 rtl/hilo_muldiv_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle HI/LO multiply/divide sequencer.
// Shift-add multiplier and restoring divider, WIDTH iterations each.
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_FIX, S_DONE, S_DIV0
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               div_q, div_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   trial;
    logic [2*WIDTH-1:0] div_nxt;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign abs_a = (op[0] && opa[WIDTH-1]) ? -opa : opa;
    assign abs_b = (op[0] && opb[WIDTH-1]) ? -opb : opb;

    // Accumulator holds {upper, multiplier}; carry out of the add is shifted back in.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

    // Accumulator holds {remainder, quotient} for the divider.
    assign rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign trial   = {1'b0, rem_sh} - {2'b00, b_q};
    assign div_nxt = trial[WIDTH+1]
                   ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                   : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    // Sign flags are only ever set for signed ops, so unsigned ops pass through.
    assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quot_fix = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0]
                                    : acc_q[WIDTH-1:0];
    assign rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH]
                           : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        div_d   = div_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    div_d = op[1];
                    sa_d  = op[0] & opa[WIDTH-1];
                    sb_d  = op[0] & opb[WIDTH-1];
                    cnt_d = CW'(WIDTH - 1);
                    if (op[1] && opb == '0) begin
                        acc_d   = {{WIDTH{1'b0}}, opa};
                        b_d     = '0;
                        state_d = S_DIV0;
                    end else if (op[1]) begin
                        acc_d   = {{WIDTH{1'b0}}, abs_a};
                        b_d     = abs_b;
                        state_d = S_RUN;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, abs_b};
                        b_d     = abs_a;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = div_q ? div_nxt : mul_nxt;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    state_d = S_DONE;
                end
            end
            S_DIV0: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d    = acc_q[WIDTH-1:0];
                    lo_d    = '1;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            div_q   <= div_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign hilo_we = (state_q == S_DONE);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule
